sram_responder: RTL

Synthesizable single-clock responder that models the external asynchronous SRAM sitting on the controller's pin-side bus (address, 16-bit bidirectional data, active-low OEn/WEn). It stands in for the physical SRAM chip in FPGA self-test builds and simulation. Writes commit into an on-chip array at the end of each WEn-low pulse. Reads return data onto the shared bus after a programmable latency. Status counters and a sticky range error expose traffic to the debug/test logic.

---
 rtl/sram_responder.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/sram_responder.sv
// Pin-level stand-in for an external asynchronous SRAM: registered input stage, writes that
// commit when WEn rises, pipelined reads with programmable latency, and debug counters.
module sram_responder #(
    parameter int AW       = 12,
    parameter int READ_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [19:0] sram_Address_io,
    inout  wire  [15:0] sram_data_io,
    input  logic        sram_OEn_io,
    input  logic        sram_WEn_io,
    output logic [15:0] wr_count,
    output logic [15:0] rd_count,
    output logic        oob_err
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ
    } state_e;

    // Input stage
    logic [19:0] a_q;
    logic [19:0] a_prev_q;
    logic [15:0] d_q;
    logic        oen_q;
    logic        wen_q;
    logic        rd_prev_q;

    // Pending write, counters, sticky error
    logic [19:0] pend_addr_q;
    logic [15:0] pend_data_q;
    logic        pend_vld_q;
    logic [15:0] wr_count_q;
    logic [15:0] rd_count_q;
    logic        oob_q;

    // Storage and the first read stage
    logic [15:0] mem [2**AW];
    logic [15:0] mem_rd_q;
    logic [15:0] fwd_data_q;
    logic        rd_vld_q;
    logic        rd_fwd_q;
    logic        rd_oob_q;

    state_e      state;
    logic        a_oob;
    logic        pend_oob;
    logic        commit_ok;
    logic        rd_req;
    logic        rd_start;
    logic        fwd_hit;
    logic [15:0] rd_data;
    logic [15:0] out_data;
    logic        out_vld;
    logic        drive;

    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state     = ST_IDLE;
        a_oob     = 1'b0;
        pend_oob  = 1'b0;
        commit_ok = 1'b0;
        rd_req    = 1'b0;
        rd_start  = 1'b0;
        fwd_hit   = 1'b0;

        if (!wen_q) begin
            state = ST_WRITE;
        end else if (!oen_q) begin
            state = ST_READ;
        end

        a_oob     = (a_q >> AW) != '0;
        pend_oob  = (pend_addr_q >> AW) != '0;
        // A pending write lands on the first edge after the WEn pulse has been seen to end.
        commit_ok = pend_vld_q && wen_q && !pend_oob;
        rd_req    = (state == ST_READ);
        rd_start  = rd_req && (!rd_prev_q || (a_q != a_prev_q));
        fwd_hit   = commit_ok && (pend_addr_q == a_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            a_q         <= '0;
            a_prev_q    <= '0;
            d_q         <= '0;
            oen_q       <= 1'b1;
            wen_q       <= 1'b1;
            rd_prev_q   <= 1'b0;
            pend_addr_q <= '0;
            pend_data_q <= '0;
            pend_vld_q  <= 1'b0;
            wr_count_q  <= '0;
            rd_count_q  <= '0;
            oob_q       <= 1'b0;
            fwd_data_q  <= '0;
            rd_vld_q    <= 1'b0;
            rd_fwd_q    <= 1'b0;
            rd_oob_q    <= 1'b0;
        end else begin
            a_q       <= sram_Address_io;
            d_q       <= sram_data_io;
            oen_q     <= sram_OEn_io;
            wen_q     <= sram_WEn_io;
            a_prev_q  <= a_q;
            rd_prev_q <= rd_req;

            if (state == ST_WRITE) begin
                pend_addr_q <= a_q;
                pend_data_q <= d_q;
                pend_vld_q  <= 1'b1;
            end else begin
                pend_vld_q  <= 1'b0;
            end

            if (commit_ok) begin
                wr_count_q <= wr_count_q + 16'd1;
            end
            if (rd_start) begin
                rd_count_q <= rd_count_q + 16'd1;
            end
            if ((state != ST_IDLE) && a_oob) begin
                oob_q <= 1'b1;
            end

            rd_vld_q   <= rd_req;
            rd_fwd_q   <= fwd_hit;
            rd_oob_q   <= a_oob;
            fwd_data_q <= pend_data_q;
        end
    end

    // NOTE: the array and its read register carry no reset; contents survive rst by design.
    always_ff @(posedge clk) begin
        if (commit_ok) begin
            mem[pend_addr_q[AW-1:0]] <= pend_data_q;
        end
        mem_rd_q <= mem[a_q[AW-1:0]];
    end

    always_comb begin
        rd_data = mem_rd_q;
        if (rd_oob_q) begin
            rd_data = '0;
        end else if (rd_fwd_q) begin
            rd_data = fwd_data_q;
        end
    end

    if (READ_LAT == 1) begin : g_lat1
        assign out_data = rd_data;
        assign out_vld  = rd_vld_q;
    end else begin : g_latn
        logic [15:0] dly_data_q [READ_LAT-1];
        logic        dly_vld_q  [READ_LAT-1];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int i = 0; i < READ_LAT - 1; i++) begin
                    dly_data_q[i] <= '0;
                    dly_vld_q[i]  <= 1'b0;
                end
            end else begin
                dly_data_q[0] <= rd_data;
                dly_vld_q[0]  <= rd_vld_q;
                for (int i = 1; i < READ_LAT - 1; i++) begin
                    dly_data_q[i] <= dly_data_q[i-1];
                    dly_vld_q[i]  <= dly_vld_q[i-1];
                end
            end
        end

        assign out_data = dly_data_q[READ_LAT-2];
        assign out_vld  = dly_vld_q[READ_LAT-2];
    end

    // The live pins gate the driver so a controller turnaround never fights stale read data.
    assign drive        = out_vld && sram_WEn_io && !sram_OEn_io;
    assign sram_data_io = drive ? out_data : 16'bz;

    assign wr_count = wr_count_q;
    assign rd_count = rd_count_q;
    assign oob_err  = oob_q;

endmodule
